// File: rtl/mul_sign_ctrl.sv
// Sign/magnitude wrapper around an unsigned 32x32 multiplier for the RV32M MUL group.
// Optional build macro MUL_FAST_ZERO_EN short-circuits requests with a zero operand.
module mul_sign_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        illegal,
    output logic        stall,
    output logic        mul_in_valid,
    output logic [31:0] mul_mplier,
    output logic [31:0] mul_mcand,
    input  logic [63:0] mul_product,
    input  logic        mul_out_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t      state_reg;
    logic [31:0] result_reg;
    logic        result_valid_reg;
    logic        illegal_reg;
    logic        mul_in_valid_reg;
    logic [31:0] mplier_reg;
    logic [31:0] mcand_reg;
    logic [63:0] product_reg;
    logic        negate_reg;
    logic        hi_sel_reg;

    logic        signed_a;
    logic        signed_b;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        negate_next;
    logic        zero_op;
    logic [63:0] fixed_product;

    // MULHU treats both operands unsigned; MULHSU only rs1 signed.
    assign signed_a    = ~(funct3[1] & funct3[0]);
    assign signed_b    = ~funct3[1];
    assign neg_a       = signed_a & rs1[31];
    assign neg_b       = signed_b & rs2[31];
    assign mag_a       = neg_a ? (~rs1 + 32'd1) : rs1;
    assign mag_b       = neg_b ? (~rs2 + 32'd1) : rs2;
    assign negate_next = neg_a ^ neg_b;

`ifdef MUL_FAST_ZERO_EN
    assign zero_op = (rs1 == 32'd0) || (rs2 == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    assign fixed_product = negate_reg ? (~product_reg + 64'd1) : product_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            result_reg       <= 32'd0;
            result_valid_reg <= 1'b0;
            illegal_reg      <= 1'b0;
            mul_in_valid_reg <= 1'b0;
            mplier_reg       <= 32'd0;
            mcand_reg        <= 32'd0;
            product_reg      <= 64'd0;
            negate_reg       <= 1'b0;
            hi_sel_reg       <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            illegal_reg      <= 1'b0;
            mul_in_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        negate_reg <= negate_next;
                        hi_sel_reg <= (funct3[1:0] != 2'b00);
                        if (funct3[2]) begin
                            result_reg       <= 32'd0;
                            result_valid_reg <= 1'b1;
                            illegal_reg      <= 1'b1;
                            state_reg        <= ST_DONE;
                        end else if (zero_op) begin
                            product_reg <= 64'd0;
                            state_reg   <= ST_FIX;
                        end else begin
                            mplier_reg       <= mag_a;
                            mcand_reg        <= mag_b;
                            mul_in_valid_reg <= 1'b1;
                            state_reg        <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state_reg <= ST_WAIT;
                ST_WAIT: begin
                    if (mul_out_valid) begin
                        product_reg <= mul_product;
                        state_reg   <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_reg       <= hi_sel_reg ? fixed_product[63:32] : fixed_product[31:0];
                    result_valid_reg <= 1'b1;
                    state_reg        <= ST_DONE;
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The IDLE term lets the processor stall in the very cycle it issues.
    assign stall = ((state_reg == ST_IDLE) && req_valid) ||
                   (state_reg == ST_ISSUE) ||
                   (state_reg == ST_WAIT)  ||
                   (state_reg == ST_FIX);

    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign illegal      = illegal_reg;
    assign mul_in_valid = mul_in_valid_reg;
    assign mul_mplier   = mplier_reg;
    assign mul_mcand    = mcand_reg;

endmodule

// File: tb/tb_mul_sign_ctrl.sv
// Directed bench for mul_sign_ctrl with a behavioural 8-iteration multiplier model.
module tb_mul_sign_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] result;
    logic        result_valid;
    logic        illegal;
    logic        stall;
    logic        mul_in_valid;
    logic [31:0] mul_mplier;
    logic [31:0] mul_mcand;
    logic [63:0] mul_product;
    logic        mul_out_valid;

    int n_vec = 0;
    int n_err = 0;

    mul_sign_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .result       (result),
        .result_valid (result_valid),
        .illegal      (illegal),
        .stall        (stall),
        .mul_in_valid (mul_in_valid),
        .mul_mplier   (mul_mplier),
        .mul_mcand    (mul_mcand),
        .mul_product  (mul_product),
        .mul_out_valid(mul_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: launch seen in cycle N, product pulse in cycle N+9.
    initial begin
        int cnt;
        cnt = 0;
        mul_out_valid = 1'b0;
        mul_product   = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
                mul_out_valid = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt = cnt - 1;
                    mul_out_valid = (cnt == 0);
                end else begin
                    mul_out_valid = 1'b0;
                end
                if (mul_in_valid) begin
                    cnt = 9;
                    mul_product = {32'd0, mul_mplier} * {32'd0, mul_mcand};
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input bit exp_ill, input int exp_launch,
                          input logic [31:0] exp_mpl, input logic [31:0] exp_mcd,
                          input int hold);
        int cyc;
        int lat;
        int launches;
        bit stall_bad;
        logic [31:0] mpl_seen;
        logic [31:0] mcd_seen;
        cyc = 0; lat = -1; launches = 0; stall_bad = 0;
        mpl_seen = 32'd0; mcd_seen = 32'd0;
        @(negedge clk);
        req_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        #1;
        check({name, ".stall_c0"}, 64'(stall), 64'd1);
        while (lat < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc > hold) req_valid = 1'b0;
            else rs1 = ~a;
            #1;
            if (mul_in_valid) begin
                launches++;
                mpl_seen = mul_mplier;
                mcd_seen = mul_mcand;
            end
            if (result_valid) lat = cyc;
            else if (!stall) stall_bad = 1'b1;
        end
        req_valid = 1'b0;
        if (lat < 0) lat = 999;
        check({name, ".latency"}, 64'(lat), 64'(exp_lat));
        check({name, ".result"}, 64'(result), 64'(exp_res));
        check({name, ".illegal"}, 64'(illegal), 64'(exp_ill));
        check({name, ".stall_done"}, 64'(stall), 64'd0);
        check({name, ".stall_busy"}, 64'(stall_bad), 64'd0);
        check({name, ".launches"}, 64'(launches), 64'(exp_launch));
        if (exp_launch != 0) begin
            check({name, ".mplier"}, 64'(mpl_seen), 64'(exp_mpl));
            check({name, ".mcand"}, 64'(mcd_seen), 64'(exp_mcd));
        end
        @(negedge clk);
        #1;
        check({name, ".rv_pulse"}, 64'(result_valid), 64'd0);
        check({name, ".held"}, 64'(result), 64'(exp_res));
        $display("op %-10s f3=%b rs1=%h rs2=%h -> result=%h lat=%0d illegal=%0d",
                 name, f3, a, b, result, lat, exp_ill);
    endtask

    initial begin
        int fz_lat;
        int fz_launch;
        rst = 1'b1; req_valid = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst.result", 64'(result), 64'd0);
        check("rst.outs", 64'({result_valid, illegal, stall, mul_in_valid}), 64'd0);
        check("rst.mags", {mul_mplier, mul_mcand}, 64'd0);
        $display("reset applied, outputs idle");
        rst = 1'b0;

        run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 32'h0000002A, 12, 0, 1, 32'd7, 32'd6, 0);
        run_op("mul_m3x5", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 12, 0, 1, 32'd3, 32'd5, 3);
        run_op("illegal", 3'b100, 32'd9, 32'd9, 32'h00000000, 1, 1, 0, 32'd0, 32'd0, 0);
        run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 12, 0, 1,
               32'h80000000, 32'h80000000, 0);
        run_op("mulh_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 12, 0, 1,
               32'd1, 32'd1, 0);
        run_op("mulh_neg", 3'b001, 32'h80000000, 32'd1, 32'hFFFFFFFF, 12, 0, 1,
               32'h80000000, 32'd1, 0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 12, 0, 1,
               32'd1, 32'd2, 0);
        run_op("illegal7", 3'b111, 32'd1, 32'd1, 32'h00000000, 1, 1, 0, 32'd0, 32'd0, 0);
        run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 12, 0, 1,
               32'hFFFFFFFF, 32'hFFFFFFFF, 0);

        // Reset mid-flight: request in cycle 0, reset sampled at the end of cycle 5.
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b001; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst.result", 64'(result), 64'd0);
        check("midrst.outs", 64'({result_valid, illegal, stall, mul_in_valid}), 64'd0);
        check("midrst.mags", {mul_mplier, mul_mcand}, 64'd0);
        $display("reset during mulh, outputs idle");
        rst = 1'b0;
        repeat (15) @(negedge clk);
        run_op("mul_3x5", 3'b000, 32'd3, 32'd5, 32'h0000000F, 12, 0, 1, 32'd3, 32'd5, 0);

`ifdef MUL_FAST_ZERO_EN
        fz_lat = 2; fz_launch = 0;
`else
        fz_lat = 12; fz_launch = 1;
`endif
        run_op("mulhu_zero", 3'b011, 32'd0, 32'h12345678, 32'h00000000, fz_lat, 0, fz_launch,
               32'd0, 32'h12345678, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_sign_ctrl.md
# mul_sign_ctrl

- Sits between the processor's execute stage and the 8-iteration unsigned multiplier. It handles the RV32M multiply group: MUL, MULH, MULHSU and MULHU.
- Upstream, it latches the operands and converts signed operands to magnitudes, then launches the unsigned multiplier.
- Downstream, it captures the 64-bit product, applies the sign correction and selects the upper or lower word.
- It holds the processor stalled until the 32-bit result is ready.

## Interface
Parameters:
- none (widths fixed at RV32)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  processor issues an M-group multiply this cycle
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx illegal here
- rs1  in  32  operand A (multiplier)
- rs2  in  32  operand B (multiplicand)
- result  out  32  selected, sign-corrected result; held until the next completion
- result_valid  out  1  one-cycle pulse, result is valid
- illegal  out  1  one-cycle pulse alongside result_valid when funct3[2]=1
- stall  out  1  processor must hold its pipeline
- mul_in_valid  out  1  one-cycle launch pulse to the multiplier
- mul_mplier  out  32  unsigned magnitude of A
- mul_mcand  out  32  unsigned magnitude of B
- mul_product  in  64  unsigned product from the multiplier
- mul_out_valid  in  1  multiplier product valid (one-cycle pulse)

## Operation
States and transitions:
- IDLE: if req_valid=1, latch the opcode and operands, then:
  - funct3[2]=1 → DONE
  - otherwise → ISSUE
- ISSUE: mul_in_valid=1 → WAIT.
- WAIT: when mul_out_valid=1, capture mul_product → FIX; otherwise stay in WAIT.
- FIX: compute the corrected product and register the selected word → DONE.
- DONE: result_valid=1, and illegal=1 if the opcode was illegal → IDLE.

Sign rules (a = rs1[31], b = rs2[31]):
- MUL, MULH: both operands signed; negate = a^b.
- MULHSU: A signed, B unsigned; negate = a.
- MULHU: neither signed; negate = 0.
- Magnitude of a signed operand is its two's-complement absolute value. 0x80000000 maps to 0x80000000 unsigned, so no overflow occurs.
- Corrected product = negate ? (~P + 1) mod 2^64 : P, where P = mul_product.
- MUL selects bits [31:0]; MULH, MULHSU and MULHU select bits [63:32].

Illegal opcode:
- Does not touch the multiplier.
- result is set to 0x00000000.

Request acceptance:
- req_valid is sampled only in IDLE and ignored in every other state.
- mul_mplier and mul_mcand are driven from registers and stay stable from ISSUE through WAIT.

Reset:
- Reset in any state forces IDLE and discards the in-flight operation.
- The multiplier shares rst, so it is cleared in the same cycle.

## Timing
Reset values:
- result=0, result_valid=0, illegal=0, stall=0, mul_in_valid=0, mul_mplier=0, mul_mcand=0.

stall:
- Combinational: stall = (IDLE & req_valid) | ISSUE | WAIT | FIX.
- stall is low in DONE, so the processor advances on the DONE edge.

Latency, with the request in cycle 0 (8-iteration multiplier):
- mul_in_valid in cycle 1.
- Multiplier computes in cycles 2–9; mul_out_valid in cycle 10.
- FIX in cycle 11; result_valid in cycle 12.
- In general the latency is the multiplier latency + 3 cycles.
- Illegal opcode: result_valid and illegal in cycle 1.

Throughput and edge cases:
- Back-to-back requests: a new request is accepted no earlier than the cycle after DONE.
- mul_out_valid arriving outside WAIT is ignored.

## Configuration
- MUL_FAST_ZERO_EN defined: in IDLE, if rs1==0 or rs2==0 (legal opcode):
  - skip ISSUE and WAIT and go straight to FIX with the product forced to 0;
  - result_valid arrives in cycle 2 with result 0;
  - the multiplier is not launched.
- MUL_FAST_ZERO_EN undefined: every legal request goes through the multiplier with full latency.

## Test plan
- MUL, rs1=7, rs2=6 → result_valid in cycle 12, result 0x0000002A; stall high in cycles 0–11, low in cycle 12.
- MULH, rs1=rs2=0x80000000 → result 0x40000000. MULH, rs1=rs2=0xFFFFFFFF → result 0x00000000. In both cases mul_mplier=mul_mcand=0x80000000 or 0x00000001 respectively.
- MULHSU, rs1=0xFFFFFFFF, rs2=0x00000002 → result 0xFFFFFFFF. MULHU, rs1=rs2=0xFFFFFFFF → result 0xFFFFFFFE.
- funct3=100 → illegal=1 and result_valid=1 in cycle 1, result 0, mul_in_valid never asserted.
- Assert rst in cycle 5 of a MULH → next cycle is IDLE with all outputs 0. A new MUL 3×5 issued afterwards → result 0x0000000F at the normal latency.
- With MUL_FAST_ZERO_EN: MULHU, rs1=0, rs2=0x12345678 → result 0 in cycle 2, no mul_in_valid. Without the macro: result 0 in cycle 12.
